// File: rtl/fibo_word_packer_pkg.sv
// fibo_word_packer_pkg: shared types and constants for the Fibonacci word packer.
package fibo_word_packer_pkg;
    localparam int FIFO_DEPTH = 2;
    localparam int HIST_FULL = 2;
    localparam int MAX_LANES = 8;
    typedef logic [7:0] term_t;
    typedef struct packed {
        logic [8*MAX_LANES-1:0] data;
        logic                   err;
    } pword_t;
endpackage

// File: rtl/fibo_word_fifo2.sv
// fibo_word_fifo2: two-entry valid/ready FIFO with a registered head entry.
module fibo_word_fifo2
    import fibo_word_packer_pkg::*;
#(
    parameter type T = pword_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       push,
    input  T           push_data,
    input  logic       pop,
    output T           head,
    output logic [1:0] count
);
    T           e0_q, e0_d, e1_q, e1_d;
    logic [1:0] count_q, count_d, c;
    logic       do_pop, do_push;

    always_comb begin
        do_pop = pop && count_q != 2'd0;
        do_push = push && (count_q != 2'(FIFO_DEPTH) || do_pop);
        c = count_q - {1'b0, do_pop};
        e0_d = do_pop ? e1_q : e0_q;
        e1_d = e1_q;
        if (do_push && c == 2'd0) e0_d = push_data;
        if (do_push && c != 2'd0) e1_d = push_data;
        count_d = c + {1'b0, do_push};
        if (clr) begin
            e0_d = '0;
            e1_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q <= '0;
            e1_q <= '0;
            count_q <= '0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            count_q <= count_d;
        end
    end

    assign head = e0_q;
    assign count = count_q;
endmodule

// File: rtl/fibo_word_packer.sv
// fibo_word_packer: checks Fibonacci byte terms and packs LANES of them per little-endian word.
module fibo_word_packer
    import fibo_word_packer_pkg::*;
#(
    parameter int LANES = 4,
    parameter bit CHECK_EN = 1'b1,
    parameter int ERRCNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_sticky,
    output logic [ERRCNT_W-1:0]  err_cnt,
    output logic [15:0]          word_cnt
);
    localparam int LW = $clog2(LANES);
    localparam int DW = 8 * LANES;
    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } word_t;

    logic [LW-1:0]       lane_q, lane_d;
    logic [DW-1:0]       asm_q, asm_d;
    logic                werr_q, werr_d;
    logic [1:0]          hist_q, hist_d;
    term_t               p1_q, p1_d, p2_q, p2_d, sum;
    logic                sticky_q, sticky_d;
    logic [ERRCNT_W-1:0] ecnt_q, ecnt_d;
    logic [15:0]         wcnt_q, wcnt_d;
    logic                last, accept, mismatch, push;
    logic [1:0]          fifo_count;
    word_t               push_word, head;

    // in_ready looks only at registered state, never at out_ready
    assign last = lane_q == LW'(LANES - 1);
    assign in_ready = !(last && fifo_count == 2'(FIFO_DEPTH));
    assign accept = in_valid && in_ready && !clr;
    assign sum = p1_q + p2_q;
    assign mismatch = CHECK_EN && accept && hist_q == 2'(HIST_FULL) && in_data != sum;
    assign push = accept && last;
    assign push_word = {asm_d, werr_q | mismatch};

    always_comb begin
        asm_d = asm_q;
        if (accept) asm_d[8*lane_q +: 8] = in_data;
        lane_d = accept ? lane_q + 1'b1 : lane_q;
        werr_d = push ? 1'b0 : werr_q | mismatch;
        hist_d = (accept && hist_q != 2'(HIST_FULL)) ? hist_q + 2'd1 : hist_q;
        p1_d = accept ? in_data : p1_q;
        p2_d = accept ? p1_q : p2_q;
        sticky_d = sticky_q | mismatch;
        ecnt_d = (mismatch && ecnt_q != '1) ? ecnt_q + 1'b1 : ecnt_q;
        wcnt_d = push ? wcnt_q + 16'd1 : wcnt_q;
        if (clr) begin
            asm_d = '0;
            lane_d = '0;
            werr_d = 1'b0;
            hist_d = '0;
            p1_d = '0;
            p2_d = '0;
            sticky_d = 1'b0;
            ecnt_d = '0;
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
            lane_q <= '0;
            werr_q <= 1'b0;
            hist_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            sticky_q <= 1'b0;
            ecnt_q <= '0;
            wcnt_q <= '0;
        end else begin
            asm_q <= asm_d;
            lane_q <= lane_d;
            werr_q <= werr_d;
            hist_q <= hist_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
            sticky_q <= sticky_d;
            ecnt_q <= ecnt_d;
            wcnt_q <= wcnt_d;
        end
    end

    fibo_word_fifo2 #(.T(word_t)) u_fifo (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .push(push),
        .push_data(push_word),
        .pop(out_ready),
        .head(head),
        .count(fifo_count)
    );

    assign out_data = head.data;
    assign out_err = head.err;
    assign out_valid = fifo_count != 2'd0;
    assign err_sticky = sticky_q;
    assign err_cnt = ecnt_q;
    assign word_cnt = wcnt_q;
endmodule

// File: tb/tb_fibo_word_packer.sv
// tb_fibo_word_packer: table vectors, corner sequences and random traffic against a queue-based model.
module tb_fibo_word_packer;
    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, in_ready, out_valid, out_ready, out_err, err_sticky;
    logic [7:0]  in_data, err_cnt;
    logic [31:0] out_data;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    fibo_word_packer #(.LANES(LANES), .CHECK_EN(1'b1), .ERRCNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .err_sticky(err_sticky), .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    int tests = 0, fails = 0;

    // reference model: recent terms, bytes of the word in progress, queued words
    logic [7:0]  m_hist[$];
    logic [7:0]  m_cur[$];
    logic [31:0] m_fd[$];
    logic        m_fe[$];
    logic        m_werr, m_sticky;
    int          m_ecnt, m_wcnt;

    logic [31:0] got_d[$];
    logic        got_e[$];
    int          dut_acc;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic void m_reset();
        m_hist.delete();
        m_cur.delete();
        m_fd.delete();
        m_fe.delete();
        m_werr = 1'b0;
        m_sticky = 1'b0;
        m_ecnt = 0;
        m_wcnt = 0;
    endfunction

    function automatic logic m_ready();
        return !(m_cur.size() == LANES - 1 && m_fd.size() == 2);
    endfunction

    function automatic logic [7:0] m_next();
        if (m_hist.size() < 2) return 8'd1;
        return 8'((int'(m_hist[0]) + int'(m_hist[1])) % 256);
    endfunction

    function automatic void m_update(logic v, logic [7:0] d, logic ordy, logic c);
        logic        acc, mis;
        logic [31:0] w;
        if (c) begin
            m_reset();
            return;
        end
        acc = v && m_ready();
        if (ordy && m_fd.size() > 0) begin
            void'(m_fd.pop_front());
            void'(m_fe.pop_front());
        end
        if (acc) begin
            mis = m_hist.size() == 2 && d != m_next();
            m_hist.push_back(d);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
            if (mis) begin
                m_sticky = 1'b1;
                m_werr = 1'b1;
                if (m_ecnt < 255) m_ecnt++;
            end
            m_cur.push_back(d);
            if (m_cur.size() == LANES) begin
                w = '0;
                for (int i = 0; i < LANES; i++) w |= 32'(m_cur[i]) << (8 * i);
                m_fd.push_back(w);
                m_fe.push_back(m_werr);
                m_werr = 1'b0;
                m_cur.delete();
                m_wcnt = (m_wcnt + 1) % 65536;
            end
        end
    endfunction

    task automatic check_outputs();
        chk("in_ready", in_ready, m_ready());
        chk("out_valid", out_valid, m_fd.size() > 0);
        if (m_fd.size() > 0) begin
            chk("out_data", out_data, m_fd[0]);
            chk("out_err", out_err, m_fe[0]);
        end
        chk("err_sticky", err_sticky, m_sticky);
        chk("err_cnt", err_cnt, m_ecnt);
        chk("word_cnt", word_cnt, m_wcnt);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic c);
        @(negedge clk);
        check_outputs();
        in_valid = v;
        in_data = d;
        out_ready = ordy;
        clr = c;
        if (out_valid && ordy && !c) begin
            got_d.push_back(out_data);
            got_e.push_back(out_err);
        end
        if (v && in_ready && !c) dut_acc++;
        @(posedge clk);
        m_update(v, d, ordy, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
        got_d.delete();
        got_e.delete();
        dut_acc = 0;
    endtask

    typedef struct {
        int          n;
        logic [7:0]  b[8];
        int          nw;
        logic [31:0] w[2];
        logic        e[2];
        logic        sticky;
        int          ecnt;
    } vec_t;

    vec_t vt[3];

    initial begin
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_reset();
        dut_acc = 0;

        vt[0].n = 8; vt[0].b = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21};
        vt[0].nw = 2; vt[0].w = '{32'h03020101, 32'h150D0805}; vt[0].e = '{1'b0, 1'b0};
        vt[0].sticky = 1'b0; vt[0].ecnt = 0;
        vt[1].n = 4; vt[1].b = '{8'd89, 8'd144, 8'd233, 8'd121, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[1].nw = 1; vt[1].w = '{32'h79E99059, 32'h0}; vt[1].e = '{1'b0, 1'b0};
        vt[1].sticky = 1'b0; vt[1].ecnt = 0;
        vt[2].n = 8; vt[2].b = '{8'd1, 8'd1, 8'd2, 8'd4, 8'd6, 8'd10, 8'd16, 8'd26};
        vt[2].nw = 2; vt[2].w = '{32'h04020101, 32'h1A100A06}; vt[2].e = '{1'b1, 1'b0};
        vt[2].sticky = 1'b1; vt[2].ecnt = 1;

        do_reset();
        #2;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_err", out_err, 0);
        chk("rst err_sticky", err_sticky, 0);
        chk("rst err_cnt", err_cnt, 0);
        chk("rst word_cnt", word_cnt, 0);

        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int j = 0; j < vt[v].n; j++) step(1'b1, vt[v].b[j], 1'b1, 1'b0);
            repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0);
            chk($sformatf("vec%0d nwords", v), got_d.size(), vt[v].nw);
            for (int k = 0; k < vt[v].nw; k++) begin
                if (k < got_d.size()) begin
                    chk($sformatf("vec%0d word%0d", v, k), got_d[k], vt[v].w[k]);
                    chk($sformatf("vec%0d err%0d", v, k), got_e[k], vt[v].e[k]);
                end
            end
            chk($sformatf("vec%0d err_sticky", v), err_sticky, vt[v].sticky);
            chk($sformatf("vec%0d err_cnt", v), err_cnt, vt[v].ecnt);
            chk($sformatf("vec%0d word_cnt", v), word_cnt, vt[v].nw);
        end

        // backpressure: consumer stalled, producer always offering the next term
        do_reset();
        repeat (14) step(1'b1, m_next(), 1'b0, 1'b0);
        chk("bp accepted", dut_acc, 11);
        #1 chk("bp in_ready low", in_ready, 0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        #1 chk("bp in_ready after pop", in_ready, 1);
        repeat (8) step(1'b1, m_next(), 1'b1, 1'b0);

        // reset in the middle of a word discards it and restarts checking
        do_reset();
        step(1'b1, 8'd1, 1'b1, 1'b0);
        step(1'b1, 8'd1, 1'b1, 1'b0);
        do_reset();
        step(1'b1, 8'd7, 1'b1, 1'b0);
        step(1'b1, 8'd9, 1'b1, 1'b0);
        step(1'b1, 8'd16, 1'b1, 1'b0);
        step(1'b1, 8'd25, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("rstmid nwords", got_d.size(), 1);
        if (got_d.size() > 0) begin
            chk("rstmid word", got_d[0], 32'h19100907);
            chk("rstmid err", got_e[0], 0);
        end
        chk("rstmid word_cnt", word_cnt, 1);

        // counter saturation, then clr colliding with an offered byte
        do_reset();
        repeat (270) step(1'b1, 8'd1, 1'b1, 1'b0);
        chk("sat err_cnt", err_cnt, 8'hFF);
        chk("sat err_sticky", err_sticky, 1);
        step(1'b1, 8'd7, 1'b0, 1'b1);
        #1;
        chk("clr err_cnt", err_cnt, 0);
        chk("clr err_sticky", err_sticky, 0);
        chk("clr out_valid", out_valid, 0);
        chk("clr word_cnt", word_cnt, 0);
        got_d.delete();
        got_e.delete();
        step(1'b1, 8'd1, 1'b1, 1'b0);
        step(1'b1, 8'd1, 1'b1, 1'b0);
        step(1'b1, 8'd2, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("clr dropped byte", got_d.size(), 0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       v, o, c;
            logic [7:0] d;
            if ($urandom_range(0, 499) == 0) do_reset();
            v = $urandom_range(0, 3) != 0;
            o = $urandom_range(0, 2) != 0;
            c = $urandom_range(0, 199) == 0;
            d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : m_next();
            step(v, d, o, c);
        end
        step(1'b0, 8'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
